// File: rtl/mips_mmio_pkg.sv
// Shared MMIO page definitions for the single-cycle MIPS data-side responder.
// Holds the page base, register offsets, TXSTAT layout and the offset decoder.
package mips_mmio_pkg;

   localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

   localparam logic [15:0] OFF_GPIO   = 16'h0000;
   localparam logic [15:0] OFF_CYCLE  = 16'h0004;
   localparam logic [15:0] OFF_TCMP   = 16'h0008;
   localparam logic [15:0] OFF_TSTAT  = 16'h000C;
   localparam logic [15:0] OFF_TXDATA = 16'h0010;
   localparam logic [15:0] OFF_TXSTAT = 16'h0014;

   localparam int TXSTAT_FULL_BIT  = 0;
   localparam int TXSTAT_EMPTY_BIT = 1;
   localparam int TXSTAT_OVF_BIT   = 2;
   localparam int TXSTAT_COUNT_LSB = 3;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_GPIO,
      REG_CYCLE,
      REG_TCMP,
      REG_TSTAT,
      REG_TXDATA,
      REG_TXSTAT
   } mmio_reg_e;

   // Takes the word offset (byte offset bits [15:2]); byte lanes are ignored.
   function automatic mmio_reg_e mmio_decode(input logic [13:0] word_off);
      logic [15:0] off;
      mmio_reg_e   sel;
      off = {word_off, 2'b00};
      case (off)
         OFF_GPIO:   sel = REG_GPIO;
         OFF_CYCLE:  sel = REG_CYCLE;
         OFF_TCMP:   sel = REG_TCMP;
         OFF_TSTAT:  sel = REG_TSTAT;
         OFF_TXDATA: sel = REG_TXDATA;
         OFF_TXSTAT: sel = REG_TXSTAT;
         default:    sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mips_tx_fifo.sv
// Byte transmit FIFO: circular buffer drained over a valid/ready stream.
// A push into a full FIFO is accepted only if a pop frees a slot that same cycle.
module mips_tx_fifo
   import mips_mmio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 push_data,
   input  logic                       pop_ready,
   output logic [7:0]                 head,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   assign valid  = (r_count != '0);
   assign full   = (r_count == CW'(DEPTH));
   assign count  = r_count;
   assign w_pop  = valid && pop_ready;
   assign w_push = push && (!full || w_pop);
   assign drop   = push && full && !w_pop;
   // Stale storage is hidden while empty so the output reads 0 out of reset.
   assign head   = valid ? r_mem[r_rd] : 8'h00;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/mips_dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: combinational-read RAM
// plus an MMIO page with GPIO, cycle counter, compare timer and TX FIFO.
module mips_dmem_mmio
   import mips_mmio_pkg::*;
#(
   parameter int RAM_WORDS  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   output logic [31:0] mem_rdata,
   output logic [7:0]  gpio_out,
   output logic        timer_irq,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   r_ram [RAM_WORDS];
   logic [7:0]    r_gpio;
   logic [31:0]   r_cycle;
   logic [31:0]   r_tcmp;
   logic          r_flag;
   logic          r_ovf;

   logic          w_mmio;
   logic          w_mmio_wr;
   mmio_reg_e     w_reg;
   logic [AW-1:0] w_idx;
   logic          w_unused_addr;
   logic          w_push;
   logic [7:0]    w_head;
   logic          w_valid;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic          w_drop;
   logic [31:0]   w_txstat;

   assign w_mmio        = (mem_addr[31:16] == MMIO_BASE_HI);
   assign w_mmio_wr     = mem_we && w_mmio;
   assign w_reg         = mmio_decode(mem_addr[15:2]);
   assign w_idx         = mem_addr[AW+1:2];
   assign w_unused_addr = ^mem_addr[1:0];
   assign w_push        = w_mmio_wr && (w_reg == REG_TXDATA);

   // Combinational read sees the pre-edge word, so read-during-write is old data.
   always_ff @(posedge clk) begin
      if (mem_we && !w_mmio) begin
         r_ram[w_idx] <= mem_wdata;
      end
   end

   mips_tx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push),
      .push_data(mem_wdata[7:0]),
      .pop_ready(tx_ready),
      .head     (w_head),
      .valid    (w_valid),
      .full     (w_full),
      .count    (w_count),
      .drop     (w_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gpio  <= '0;
         r_cycle <= '0;
         r_tcmp  <= '1;
         r_flag  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_mmio_wr && (w_reg == REG_GPIO)) begin
            r_gpio <= mem_wdata[7:0];
         end
         if (w_mmio_wr && (w_reg == REG_TCMP)) begin
            r_tcmp <= mem_wdata;
         end
         // A match on the same edge as a clearing write keeps the flag set.
         if (r_cycle == r_tcmp) begin
            r_flag <= 1'b1;
         end else if (w_mmio_wr && ((w_reg == REG_TCMP) || (w_reg == REG_TSTAT))) begin
            r_flag <= 1'b0;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_mmio_wr && (w_reg == REG_TXSTAT)) begin
            r_ovf <= 1'b0;
         end
      end
   end

   always_comb begin
      w_txstat                                = '0;
      w_txstat[TXSTAT_FULL_BIT]               = w_full;
      w_txstat[TXSTAT_EMPTY_BIT]              = !w_valid;
      w_txstat[TXSTAT_OVF_BIT]                = r_ovf;
      w_txstat[TXSTAT_COUNT_LSB +: CW]        = w_count;
   end

   always_comb begin
      mem_rdata = '0;
      if (!w_mmio) begin
         mem_rdata = r_ram[w_idx];
      end else begin
         case (w_reg)
            REG_GPIO:   mem_rdata = {24'h0, r_gpio};
            REG_CYCLE:  mem_rdata = r_cycle;
            REG_TCMP:   mem_rdata = r_tcmp;
            REG_TSTAT:  mem_rdata = {31'h0, r_flag};
            REG_TXSTAT: mem_rdata = w_txstat;
            default:    mem_rdata = '0;
         endcase
      end
   end

   assign gpio_out  = r_gpio;
   assign timer_irq = r_flag;
   assign tx_data   = w_head;
   assign tx_valid  = w_valid;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model of the memory map.
module tb_mips_dmem_mmio;
   localparam int RAM_WORDS = 256;
   localparam int DEPTH     = 4;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic [31:0] mem_addr  = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic        mem_we    = 1'b0;
   logic        tx_ready  = 1'b0;
   logic [31:0] mem_rdata;
   logic [7:0]  gpio_out;
   logic        timer_irq;
   logic [7:0]  tx_data;
   logic        tx_valid;

   always #5 clk = ~clk;

   mips_dmem_mmio #(
      .RAM_WORDS (RAM_WORDS),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_rdata(mem_rdata),
      .gpio_out (gpio_out),
      .timer_irq(timer_irq),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [31:0] m_ram [RAM_WORDS];
   bit          m_known [RAM_WORDS];
   logic [7:0]  m_gpio;
   logic [31:0] m_cycle;
   logic [31:0] m_tcmp;
   bit          m_flag;
   bit          m_ovf;
   logic [7:0]  m_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_mmio(input logic [31:0] a);
      return a[31:16] == 16'hFFFF;
   endfunction

   function automatic int ram_idx(input logic [31:0] a);
      return int'((a / 4) % RAM_WORDS);
   endfunction

   function automatic int mmio_off(input logic [31:0] a);
      return int'(a[15:0]) / 4 * 4;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] a, output bit ok);
      int n;
      ok = 1'b1;
      n  = m_q.size();
      if (!is_mmio(a)) begin
         ok = m_known[ram_idx(a)];
         return m_ram[ram_idx(a)];
      end
      case (mmio_off(a))
         0:       return {24'h0, m_gpio};
         4:       return m_cycle;
         8:       return m_tcmp;
         12:      return {31'h0, m_flag};
         20:      return 32'((n == DEPTH ? 1 : 0) + (n == 0 ? 2 : 0) + (m_ovf ? 4 : 0) + 8 * n);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_gpio  = 8'h00;
      m_cycle = 32'h0;
      m_tcmp  = 32'hFFFF_FFFF;
      m_flag  = 1'b0;
      m_ovf   = 1'b0;
      m_q.delete();
   endtask

   // Advance the model by one clock edge using the inputs presented this cycle.
   task automatic model_step();
      bit mm, wr, was_full, popped;
      int off;
      if (rst) begin
         model_reset();
         return;
      end
      mm       = is_mmio(mem_addr);
      off      = mmio_off(mem_addr);
      wr       = mem_we;
      was_full = (m_q.size() == DEPTH);
      popped   = (m_q.size() != 0) && tx_ready;
      if (m_cycle == m_tcmp) m_flag = 1'b1;
      else if (wr && mm && (off == 8 || off == 12)) m_flag = 1'b0;
      if (wr && mm && off == 0) m_gpio = mem_wdata[7:0];
      if (wr && mm && off == 8) m_tcmp = mem_wdata;
      if (popped) void'(m_q.pop_front());
      if (wr && mm && off == 16) begin
         if (!was_full || popped) m_q.push_back(mem_wdata[7:0]);
         else m_ovf = 1'b1;
      end else if (wr && mm && off == 20) begin
         m_ovf = 1'b0;
      end
      if (wr && !mm) begin
         m_ram[ram_idx(mem_addr)]   = mem_wdata;
         m_known[ram_idx(mem_addr)] = 1'b1;
      end
      m_cycle = m_cycle + 32'd1;
   endtask

   // One bus cycle: present inputs, sample the load data, then cross the edge.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                      output logic [31:0] rd);
      mem_addr  = a;
      mem_wdata = d;
      mem_we    = we;
      #2;
      rd = mem_rdata;
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
      mem_we = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] e;
         bit ok;
         e = exp_rdata(mem_addr, ok);
         if (ok) chk("rdata", mem_rdata, e);
         chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio});
         chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_flag});
         chk("tx_valid", {31'h0, tx_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
         if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
      end
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] c;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] cyc_rd [4];
      int          pct;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_gpio", {24'h0, gpio_out}, 32'h0);
      chk("rst_irq", {31'h0, timer_irq}, 32'h0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      rst = 1'b0;

      // Counter after reset release
      for (int i = 0; i < 4; i++) begin
         cyc(32'hFFFF_0004, 32'h0, 1'b0, rd);
         cyc_rd[i] = rd;
      end
      chk("cycle_0", cyc_rd[0], 32'd0);
      chk("cycle_1", cyc_rd[1], 32'd1);
      chk("cycle_2", cyc_rd[2], 32'd2);
      chk("cycle_3", cyc_rd[3], 32'd3);

      for (int i = 0; i < RAM_WORDS; i++) cyc(32'(i * 4), $urandom, 1'b1, rd);

      // RAM aliasing and read-during-write
      cyc(32'h40, 32'hDEAD_BEEF, 1'b1, rd);
      cyc(32'h40 + 4 * RAM_WORDS, 32'h1234_5678, 1'b1, rd);
      chk("ram_rdw_old", rd, 32'hDEAD_BEEF);
      cyc(32'h40, 32'h0, 1'b0, rd);
      chk("ram_alias", rd, 32'h1234_5678);

      // GPIO and unmapped MMIO
      cyc(32'hFFFF_0000, 32'h1A5, 1'b1, rd);
      chk("gpio_write", {24'h0, gpio_out}, 32'hA5);
      cyc(32'hFFFF_0000, 32'h0, 1'b0, rd);
      chk("gpio_read", rd, 32'hA5);
      cyc(32'hFFFF_0020, 32'h0, 1'b0, rd);
      chk("unmapped_read", rd, 32'h0);

      // Timer compare, set beats same-edge clear
      cyc(32'hFFFF_0004, 32'h0, 1'b0, rd);
      c = rd;
      cyc(32'hFFFF_0008, c + 32'd6, 1'b1, rd);
      for (int i = 0; i < 4; i++) begin
         cyc(32'h0, 32'h0, 1'b0, rd);
         chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
      end
      cyc(32'hFFFF_000C, 32'h0, 1'b1, rd);
      chk("irq_set_wins", {31'h0, timer_irq}, 32'h1);
      cyc(32'hFFFF_000C, 32'h0, 1'b1, rd);
      chk("irq_cleared", {31'h0, timer_irq}, 32'h0);

      // Fill FIFO past capacity
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) cyc(32'hFFFF_0010, 32'h41 + 32'(i), 1'b1, rd);
      chk("txdata_reads_zero", rd, 32'h0);
      cyc(32'hFFFF_0014, 32'h0, 1'b0, rd);
      chk("txstat_full_ovf", rd, 32'h25);
      chk("tx_head", {24'h0, tx_data}, 32'h41);

      // Drain, then clear ovf
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", {24'h0, tx_data}, 32'h41 + 32'(i));
         cyc(32'h0, 32'h0, 1'b0, rd);
      end
      chk("drained_valid", {31'h0, tx_valid}, 32'h0);
      cyc(32'hFFFF_0014, 32'h0, 1'b0, rd);
      chk("txstat_empty_ovf", rd, 32'h6);
      cyc(32'hFFFF_0014, 32'h0, 1'b1, rd);
      cyc(32'hFFFF_0014, 32'h0, 1'b0, rd);
      chk("txstat_ovf_clear", rd, 32'h2);

      // Push into full FIFO while popping, then reset mid-drain
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc(32'hFFFF_0010, 32'h50 + 32'(i), 1'b1, rd);
      tx_ready = 1'b1;
      cyc(32'hFFFF_0010, 32'h54, 1'b1, rd);
      cyc(32'hFFFF_0014, 32'h0, 1'b0, rd);
      chk("txstat_full_nodrop", rd, 32'h21);
      chk("head_after_pops", {24'h0, tx_data}, 32'h52);
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("async_rst_gpio", {24'h0, gpio_out}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic
      pct = 50;
      for (int n = 0; n < 2000; n++) begin
         if (n % 64 == 0) pct = (n / 64) % 3 == 0 ? 10 : ((n / 64) % 3 == 1 ? 50 : 90);
         tx_ready = ($urandom_range(0, 99) < pct);
         if ($urandom_range(0, 9) < 4) begin
            a = $urandom;
            if (a[31:16] == 16'hFFFF) a[31:16] = 16'h0000;
         end else if ($urandom_range(0, 9) == 0) begin
            a = 32'hFFFF_0000 | 32'($urandom_range(0, 16'hFFFF));
         end else begin
            a = 32'hFFFF_0000 | 32'($urandom_range(0, 31));
         end
         d = $urandom;
         if (is_mmio(a) && mmio_off(a) == 8) d = m_cycle + 32'($urandom_range(0, 6));
         if (n % 500 == 250) begin
            rst = 1'b1;
            model_reset();
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
         cyc(a, d, 1'($urandom_range(0, 1)), rd);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
